// File: rtl/up_pkg.sv
// Shared encodings for the accumulator CPU control unit: state codes, opcodes, A source select.
// Latency: none (types, constants and a pure decode function only).
// Backpressure: not applicable.
package up_pkg;

  typedef enum logic [3:0] {
    S_START   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_LOAD    = 4'd3,
    S_STORE   = 4'd4,
    S_ADD     = 4'd5,
    S_SUB     = 4'd6,
    S_IN_WAIT = 4'd7,
    S_IN_REL  = 4'd8,
    S_JZ      = 4'd9,
    S_JPOS    = 4'd10,
    S_HALT    = 4'd11
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_RES = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  // Execute state entered from DECODE for a given opcode.
  function automatic state_t exec_state(input logic [2:0] op);
    case (op)
      OP_LOAD:  return S_LOAD;
      OP_STORE: return S_STORE;
      OP_ADD:   return S_ADD;
      OP_SUB:   return S_SUB;
      OP_IN:    return S_IN_WAIT;
      OP_JZ:    return S_JZ;
      OP_JPOS:  return S_JPOS;
      default:  return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/up_cu_if.sv
// Control/status bundle between the control unit (master) and the accumulator datapath (slave).
// Latency: wires only.
// Backpressure: none; strobes are single-cycle commands the datapath always accepts.
interface up_cu_if;
  logic [2:0] IR;
  logic       Aeq0;
  logic       Apos;
  logic       IRload;
  logic       JMPmux;
  logic       PCload;
  logic       Meminst;
  logic       MemWr;
  logic       Aload;
  logic       Sub;
  logic [1:0] Asel;
  logic       InReq;
  logic       Halt;
  logic [3:0] State;

  modport master (
    input  IR, Aeq0, Apos,
    output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, InReq, Halt, State
  );

  modport slave (
    output IR, Aeq0, Apos,
    input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, InReq, Halt, State
  );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clock domain.
// Latency: STAGES clock edges from input change to output change.
// Backpressure: none; the level is sampled every cycle.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the raw level through the chain; reset clears any half-captured press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/up_cu.sv
// Control unit sequencing fetch/decode/execute of the 8-bit accumulator datapath.
// Latency: 3 cycles per memory/jump instruction; IN adds the Enter wait and release.
// Backpressure: IN stalls in IN_WAIT/IN_REL on the synchronized Enter button; HALT stalls until reset.
module up_cu
  import up_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     CLOCK,
  input  logic     RESET,
  input  logic     Enter,
  up_cu_if.master  cu
);

  state_t     state, state_nxt;
  logic       enter_s;
  logic       ir_load, jmp_mux, pc_load, meminst, mem_wr, a_load, sub, in_req, halt;
  logic [1:0] asel;

  sync_ff #(.STAGES(SYNC_STAGES)) u_enter_sync (
    .clk (CLOCK),
    .rst (RESET),
    .d   (Enter),
    .q   (enter_s)
  );

  // State register; reset parks the machine in START with every strobe low.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= S_START;
    else       state <= state_nxt;
  end

  // Next-state and strobe decode; only the conditional jumps look at the A flags.
  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    jmp_mux   = 1'b0;
    pc_load   = 1'b0;
    meminst   = 1'b0;
    mem_wr    = 1'b0;
    a_load    = 1'b0;
    sub       = 1'b0;
    asel      = ASEL_RES;
    in_req    = 1'b0;
    halt      = 1'b0;
    case (state)
      S_START:  state_nxt = S_FETCH;
      S_FETCH: begin
        ir_load   = 1'b1;
        pc_load   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        meminst   = 1'b1;
        state_nxt = exec_state(cu.IR);
      end
      S_LOAD: begin
        meminst   = 1'b1;
        asel      = ASEL_MEM;
        a_load    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_STORE: begin
        meminst   = 1'b1;
        mem_wr    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ADD: begin
        meminst   = 1'b1;
        a_load    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_SUB: begin
        meminst   = 1'b1;
        sub       = 1'b1;
        a_load    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_IN_WAIT: begin
        in_req = 1'b1;
        asel   = ASEL_IN;
        // A press already held on entry is taken at once; IN_REL of the previous IN guarantees it is fresh.
        if (enter_s) begin
          a_load    = 1'b1;
          state_nxt = S_IN_REL;
        end
      end
      S_IN_REL: begin
        if (!enter_s) state_nxt = S_FETCH;
      end
      S_JZ: begin
        meminst   = 1'b1;
        pc_load   = cu.Aeq0;
        jmp_mux   = cu.Aeq0;
        state_nxt = S_FETCH;
      end
      S_JPOS: begin
        meminst   = 1'b1;
        pc_load   = cu.Apos;
        jmp_mux   = cu.Apos;
        state_nxt = S_FETCH;
      end
      S_HALT:   halt = 1'b1;
      default:  state_nxt = S_START;
    endcase
  end

  assign cu.IRload  = ir_load;
  assign cu.JMPmux  = jmp_mux;
  assign cu.PCload  = pc_load;
  assign cu.Meminst = meminst;
  assign cu.MemWr   = mem_wr;
  assign cu.Aload   = a_load;
  assign cu.Sub     = sub;
  assign cu.Asel    = asel;
  assign cu.InReq   = in_req;
  assign cu.Halt    = halt;
  assign cu.State   = state;

endmodule

// File: tb/tb_up_cu.sv
// Bench for up_cu: drives a behavioural datapath and RAM, checks retirements against an ISA-level model.
// Latency: expected results are queued at program start and consumed when the DUT retires instructions.
// Backpressure: the Enter push-button is driven in response to InReq with random wait and hold times.
module tb_up_cu;

  typedef struct {
    logic [4:0] pc;
    logic [7:0] a;
    int         cyc;
    bit         halt;
  } item_t;

  logic       CLOCK   = 1'b0;
  logic       RESET   = 1'b1;
  logic       Enter   = 1'b0;
  logic [7:0] inp     = 8'h00;
  logic       do_load = 1'b0;

  logic [7:0] ram     [32];
  logic [7:0] img     [32];
  logic [7:0] exp_mem [32];
  logic [7:0] in_vals [$];
  item_t      sbq     [$];
  logic [3:0] hist    [$];
  bit         exp_halt;

  logic [4:0] pc;
  logic [7:0] ir_r;
  logic [7:0] a;
  logic [4:0] addr;

  int n_chk  = 0;
  int n_pass = 0;

  up_cu_if bus ();

  up_cu #(.SYNC_STAGES(2)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .Enter (Enter),
    .cu    (bus)
  );

  always #5 CLOCK = ~CLOCK;

  // Datapath driven by the control strobes
  assign addr     = bus.Meminst ? ir_r[4:0] : pc;
  assign bus.IR   = ir_r[7:5];
  assign bus.Aeq0 = (a == 8'h00);
  assign bus.Apos = ~a[7];

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc   <= 5'd0;
      ir_r <= 8'h00;
      a    <= 8'h00;
      if (do_load) for (int i = 0; i < 32; i++) ram[i] <= img[i];
    end else begin
      if (bus.IRload) ir_r <= ram[addr];
      if (bus.PCload) pc <= bus.JMPmux ? ir_r[4:0] : pc + 5'd1;
      if (bus.MemWr)  ram[addr] <= a;
      if (bus.Aload) begin
        case (bus.Asel)
          2'b00:   a <= bus.Sub ? a - ram[addr] : a + ram[addr];
          2'b01:   a <= inp;
          default: a <= ram[addr];
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [14:0] outs();
    return {bus.IRload, bus.JMPmux, bus.PCload, bus.Meminst, bus.MemWr, bus.Aload, bus.Sub,
            bus.Asel, bus.InReq, bus.Halt, bus.State};
  endfunction

  // Instruction-level reference: interprets the RAM image, one queue entry per retired instruction
  task automatic run_model(input int kmax);
    logic [7:0] m [32];
    logic [4:0] p;
    logic [7:0] acc, ins;
    int         nin;
    item_t      it;
    p = 5'd0; acc = 8'h00; nin = 0; exp_halt = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = img[i];
    for (int k = 0; k < kmax && !exp_halt; k++) begin
      ins = m[p];
      p   = p + 5'd1;
      it.cyc = 3; it.halt = 1'b0;
      case (ins[7:5])
        3'd0: acc = m[ins[4:0]];
        3'd1: m[ins[4:0]] = acc;
        3'd2: acc = acc + m[ins[4:0]];
        3'd3: acc = acc - m[ins[4:0]];
        3'd4: begin
          acc = (nin < in_vals.size()) ? in_vals[nin] : 8'h00;
          nin++;
          it.cyc = 0;
        end
        3'd5: if (acc == 8'h00) p = ins[4:0];
        3'd6: if (!acc[7]) p = ins[4:0];
        default: begin exp_halt = 1'b1; it.halt = 1'b1; it.cyc = 2; end
      endcase
      it.pc = p; it.a = acc;
      sbq.push_back(it);
    end
    for (int i = 0; i < 32; i++) exp_mem[i] = m[i];
  endtask

  // Monitor: pops the scoreboard whenever the DUT retires an instruction
  logic [3:0] prev_st    = 4'd0;
  int         cyc_cnt    = 0;
  bit         started    = 1'b0;
  bit         prev_memwr = 1'b0;

  task automatic retire(input bit at_halt, input int cnt);
    item_t it;
    if (sbq.size() == 0) begin
      n_chk++;
      $display("FAIL sb_unexpected_retire: state %0d, no instruction expected", bus.State);
    end else begin
      it = sbq.pop_front();
      chk("ret_halt", 32'(at_halt), 32'(it.halt));
      chk("ret_pc",   32'(pc),      32'(it.pc));
      chk("ret_a",    32'(a),       32'(it.a));
      if (it.cyc != 0) chk("ret_cpi", 32'(cnt), 32'(it.cyc));
    end
  endtask

  always @(negedge CLOCK) begin
    if (RESET) begin
      started = 1'b0; prev_memwr = 1'b0; prev_st = 4'd0; cyc_cnt = 0;
    end else begin
      if (hist.size() < 4) hist.push_back(bus.State);
      cyc_cnt++;
      chk("excl_load", 32'((int'(bus.IRload) + int'(bus.Aload) + int'(bus.MemWr)) <= 1), 32'd1);
      if (bus.MemWr) chk("memwr_width", 32'(prev_memwr), 32'd0);
      if (bus.State == 4'd1) begin
        if (started) retire(1'b0, cyc_cnt);
        started = 1'b1;
        cyc_cnt = 0;
      end else if (bus.State == 4'd11 && prev_st != 4'd11) begin
        retire(1'b1, cyc_cnt);
      end
      prev_st    = bus.State;
      prev_memwr = bus.MemWr;
    end
  end

  task automatic start_prog(input bit use_model);
    RESET = 1'b1;
    Enter = 1'b0;
    sbq.delete();
    if (use_model) run_model(40);
    do_load = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1;
    do_load = 1'b0;
    hist.delete();
    RESET = 1'b0;
  endtask

  task automatic run_prog(input int budget);
    int phase, wcnt, hcnt, nin, cyc, nbad;
    bit done;
    start_prog(1'b1);
    phase = 0; wcnt = 0; hcnt = 0; nin = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < budget) begin
      @(posedge CLOCK); #1;
      cyc++;
      case (phase)
        0: if (bus.InReq) begin wcnt = $urandom_range(0, 6); phase = 1; end
        1: if (wcnt == 0) begin
             inp   = (nin < in_vals.size()) ? in_vals[nin] : 8'h00;
             nin++;
             Enter = 1'b1;
             hcnt  = $urandom_range(1, 4);
             phase = 2;
           end else wcnt--;
        2: begin
             hcnt--;
             if (hcnt == 0) begin Enter = 1'b0; phase = 3; end
           end
        default: if (!bus.InReq) phase = 0;
      endcase
      if (sbq.size() == 0 && (!exp_halt || bus.Halt)) done = 1'b1;
    end
    chk("prog_done", 32'(done), 32'd1);
    nbad = 0;
    for (int i = 0; i < 32; i++) if (ram[i] !== exp_mem[i]) nbad++;
    chk("ram_image", 32'(nbad), 32'd0);
    Enter = 1'b0;
  endtask

  initial begin
    int n, bad, nld;
    logic [15:0] hv;
    for (int i = 0; i < 32; i++) img[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge CLOCK); #1;
    chk("reset_outs", 32'(outs()), 32'd0);

    // LOAD 3 straight out of reset
    img[0] = 8'h03; img[1] = 8'hE0; img[3] = 8'h2A;
    in_vals.delete();
    run_prog(200);
    hv = (hist.size() >= 4) ? {hist[0], hist[1], hist[2], hist[3]} : 16'hFFFF;
    chk("start_seq", 32'(hv), 32'h0123);
    chk("load_a", 32'(a), 32'h2A);

    // Arithmetic wrap, store, conditional jumps
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[20] = 8'hF0; img[21] = 8'h20; img[22] = 8'h11; img[23] = 8'h5C;
    img[24] = 8'h00; img[25] = 8'h80; img[26] = 8'h01;
    img[0] = 8'h14; img[1] = 8'h55; img[2] = 8'h76; img[3] = 8'h17; img[4] = 8'h3F;
    img[5] = 8'h18; img[6] = 8'hA8; img[7] = 8'hE0; img[8] = 8'h19; img[9] = 8'hC7;
    img[10] = 8'h1A; img[11] = 8'hCD; img[12] = 8'hE0; img[13] = 8'hE0;
    run_prog(300);
    chk("store_ram31", 32'(ram[31]), 32'h5C);
    chk("jpos_pc", 32'(pc), 32'd14);

    // Jump to 31, then PC wraps to 0
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0] = 8'hBF; img[1] = 8'hE0; img[30] = 8'h05; img[31] = 8'h1E;
    run_prog(200);
    chk("wrap_a", 32'(a), 32'h05);

    // Random programs with random Enter timing
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
      for (int i = 0; i < 20; i++) begin
        logic [2:0] op;
        logic [4:0] ad;
        op = 3'($urandom_range(0, 7));
        if (op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'd2;
        ad = (op == 3'd5 || op == 3'd6) ? 5'($urandom_range(0, 19)) : 5'($urandom_range(20, 31));
        img[i] = {op, ad};
      end
      in_vals.delete();
      for (int i = 0; i < 40; i++) in_vals.push_back(8'($urandom));
      run_prog(2000);
    end

    // IN handshake with exact timing, then HALT
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0] = 8'h80; img[1] = 8'hE0;
    in_vals.delete(); in_vals.push_back(8'h77);
    start_prog(1'b1);
    n = 0;
    while (!bus.InReq && n < 30) begin @(posedge CLOCK); #1; n++; end
    chk("in_wait_entry", 32'(bus.InReq), 32'd1);
    bad = 0;
    repeat (10) begin @(posedge CLOCK); #1; if (!bus.InReq || bus.Aload) bad++; end
    chk("in_wait_hold", 32'(bad), 32'd0);
    inp = 8'h77; Enter = 1'b1; nld = 0;
    @(posedge CLOCK); #1;
    chk("in_not_early", 32'(bus.Aload), 32'd0);
    if (bus.Aload) nld++;
    @(posedge CLOCK); #1;
    chk("in_recog", 32'({bus.Aload, bus.InReq}), 32'd3);
    if (bus.Aload) nld++;
    @(posedge CLOCK); #1;
    chk("in_a", 32'(a), 32'h77);
    bad = 0;
    repeat (5) begin
      @(posedge CLOCK); #1;
      if (bus.State != 4'd8) bad++;
      if (bus.Aload) nld++;
    end
    chk("in_rel_hold", 32'(bad), 32'd0);
    Enter = 1'b0;
    n = 0;
    while (bus.State != 4'd1 && n < 10) begin
      @(posedge CLOCK); #1; n++;
      if (bus.Aload) nld++;
    end
    chk("in_rel_exit", 32'(bus.State), 32'd1);
    chk("in_single_load", 32'(nld), 32'd1);
    n = 0;
    while (!bus.Halt && n < 10) begin @(posedge CLOCK); #1; n++; end
    bad = 0;
    repeat (20) begin
      @(posedge CLOCK); #1;
      Enter = ~Enter;
      if (outs() !== 15'h001B) bad++;
    end
    chk("halt_hold", 32'(bad), 32'd0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    Enter = 1'b0;
    @(posedge CLOCK); #3;
    RESET = 1'b1;
    #1;
    chk("rst_halt_outs", 32'(outs()), 32'd0);
    chk("rst_halt_pc", 32'(pc), 32'd0);

    // Async reset in the middle of IN_WAIT
    start_prog(1'b0);
    n = 0;
    while (!bus.InReq && n < 30) begin @(posedge CLOCK); #1; n++; end
    chk("in2_wait_entry", 32'(bus.InReq), 32'd1);
    repeat (3) @(posedge CLOCK);
    #3;
    RESET = 1'b1;
    #1;
    chk("rst_inwait_outs", 32'(outs()), 32'd0);
    chk("rst_inwait_pc", 32'(pc), 32'd0);
    repeat (2) @(posedge CLOCK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/up_cu.md
Name: up_cu

Overview:
Control unit (FSM) that sequences the 8-bit accumulator datapath: fetch, decode, execute of 8-bit instructions {opcode[7:5], addr[4:0]} held in a 32x8 RAM.
- Drives all datapath control strobes from its state, the IR opcode and the A status flags.
- Runs an Enter push-button handshake for the IN instruction and stops on HALT.
- Sits beside the datapath in the CPU top level; the datapath's Init input is driven directly by the top level, not by this block.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the Enter synchronizer (legal 2..4)

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
Enter  in  1  asynchronous push-button from the user, level
IR  in  3  opcode IR[7:5] from the datapath
Aeq0  in  1  A == 0
Apos  in  1  A[7] == 0
IRload  out  1  load IR
JMPmux  out  1  1 = next PC from IR[4:0]; 0 = PC+1
PCload  out  1  load PC
Meminst  out  1  1 = RAM address from IR[4:0]; 0 = PC
MemWr  out  1  RAM write of A
Aload  out  1  load A
Sub  out  1  1 = A - M; 0 = A + M
Asel  out  2  A source: 1x = RAM, 01 = Input, 00 = add/sub result
InReq  out  1  high while waiting for Enter
Halt  out  1  high in HALT
State  out  4  current state code, debug

Behaviour:
- Opcodes (IR[7:5]): 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 IN, 101 JZ, 110 JPOS, 111 HALT.
- States: START, FETCH, DECODE, LOAD, STORE, ADD, SUB, IN_WAIT, IN_REL, JZ, JPOS, HALT; fixed 4-bit codes 0..11 in that order.
- Outputs are decoded from state only (Moore), except PCload/JMPmux in JZ/JPOS, which also depend on Aeq0/Apos. Every output not listed for a state is 0.
- RESET (async, any cycle, including mid-instruction or mid-handshake):
  - state = START; all strobes, InReq and Halt = 0; State = 0.
  - synchronizer flops cleared.
  - Datapath registers are reset by the same RESET.
- START: no strobes; next FETCH.
- FETCH: Meminst=0, IRload=1, PCload=1, JMPmux=0. IR <= M[PC], PC <= PC+1 on the same edge (5-bit PC wraps 31 -> 0). Next DECODE.
- DECODE: Meminst=1, no loads. Next state is the execute state chosen by opcode; 111 -> HALT.
- LOAD: Meminst=1, Asel=10, Aload=1 -> FETCH.
- STORE: Meminst=1, MemWr=1 -> FETCH. MemWr is asserted for exactly one cycle.
- ADD: Meminst=1, Asel=00, Sub=0, Aload=1 -> FETCH. 8-bit result; carry discarded, wraps mod 256.
- SUB: as ADD but Sub=1 -> FETCH.
- IN_WAIT: InReq=1, Asel=01.
  - Enter_s=0: stay.
  - Enter_s=1: Aload=1 this cycle, go to IN_REL.
- IN_REL: stay while Enter_s=1; Enter_s=0 -> FETCH. One IN consumes exactly one press.
- Enter already held when IN_WAIT is entered: value is taken immediately. This is intended; the previous IN's IN_REL guarantees a fresh press.
- JZ: Meminst=1; PCload=JMPmux=Aeq0 -> FETCH.
- JPOS: Meminst=1; PCload=JMPmux=Apos -> FETCH. A=0 counts as positive.
- HALT: Halt=1, all strobes 0; stays until RESET. Enter ignored.
- Enter_s is Enter after SYNC_STAGES flops. Press-to-recognition latency = SYNC_STAGES cycles.
- CPI: memory and jump instructions 3 cycles (FETCH, DECODE, EXEC); IN is 3 cycles plus wait plus release.
- Only one of IRload/Aload/MemWr may be high in any cycle. Bench asserts this.

Decomposition:
- Package up_pkg: state codes (4-bit localparams/enum), opcode constants OP_LOAD..OP_HALT, Asel codes ASEL_RES=00, ASEL_IN=01, ASEL_MEM=10.
- Sub-module sync_ff #(STAGES): reset-clearable multi-flop synchronizer for Enter.
- The FSM (next-state and output decode) stays in up_cu.

Test Plan:
- Reset/fetch: RAM[0]=8'h03 (LOAD 3), RAM[3]=8'h2A, release RESET -> START, FETCH, DECODE, LOAD; A=8'h2A at the end of cycle 4; PC=1; Halt=0.
- Arithmetic wrap: A=8'hF0, ADD with M=8'h20 -> A=8'h10. SUB with M=8'h11 from A=8'h10 -> A=8'hFF, Apos=0.
- Store: A=8'h5C, STORE 31 -> RAM[31]=8'h5C; MemWr high for exactly 1 cycle; next state FETCH.
- Jumps: A=0, JZ 7 -> PC=7. A=8'h80, JPOS 7 -> PC = old PC. A=8'h01, JPOS 9 -> PC=9.
- IN handshake, SYNC_STAGES=2: Input=8'h77, Enter asserted 10 cycles after IN_WAIT entry -> InReq high until the load, A=8'h77 two cycles after Enter rises. Enter held 5 more cycles -> state IN_REL until release, then FETCH. Only one load occurs.
- HALT and reset: opcode 111 -> Halt=1, State=11, stays for 20 cycles with Enter toggling. Async RESET pulse mid-IN_WAIT or mid-HALT -> all outputs 0 immediately, State=0, PC=0.
